// File: rtl/multilane_spi_pkg.sv
// multilane_spi_pkg: shared FSM state type, sync word and counter-width helper for the SPI streamer
package multilane_spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_state_t;
  localparam logic [15:0] SYNC_WORD = 16'hA5C3;
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/multilane_spi_streamer_serializer.sv
// spi_lane_serializer: packet FSM, dclk divider, per-lane MSB-first shifters and sent-packet counter
module spi_lane_serializer
  import multilane_spi_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int LINES           = 6,
  parameter int DATA_CLK_PERIOD = 6
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        load,
  input  logic [LINES*DATA_WIDTH-1:0] load_data,
  output logic                        ready,
  output logic [LINES-1:0]            chip_data_out,
  output logic                        chip_clk_out,
  output logic                        chip_sel_out,
  output logic [15:0]                 packets_sent_out
);
  localparam int HALF = DATA_CLK_PERIOD / 2;
  localparam int CW   = cnt_width(HALF);
  localparam int EW   = cnt_width(2 * DATA_WIDTH);
  spi_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [EW-1:0] edges;
  logic [LINES-1:0][DATA_WIDTH-1:0] sh;
  logic half_done, last_edge;
  assign half_done = cnt == CW'(HALF - 1);
  assign last_edge = edges == EW'(2 * DATA_WIDTH - 1);
  for (genvar i = 0; i < LINES; i++) begin : g_lane
    assign chip_data_out[i] = sh[i][DATA_WIDTH-1];
  end
  // state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else state <= state_nxt;
  end
  // next state: SHIFT ends on the falling edge after the last rising edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = load ? SETUP : IDLE;
      SETUP:   state_nxt = half_done ? SHIFT : SETUP;
      SHIFT:   state_nxt = (half_done && last_edge) ? HOLD : SHIFT;
      HOLD:    state_nxt = half_done ? GAP : HOLD;
      default: state_nxt = IDLE;
    endcase
  end
  // outputs decoded from state; cs is low across SETUP, SHIFT and HOLD
  always_comb begin
    ready        = state == IDLE;
    chip_sel_out = (state == IDLE) || (state == GAP);
  end
  // half-period divider, dclk, lane shifters and packet counter; data moves on dclk falling edges
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt              <= '0;
      edges            <= '0;
      chip_clk_out     <= 1'b0;
      sh               <= '0;
      packets_sent_out <= '0;
    end else begin
      cnt <= ((state inside {SETUP, SHIFT, HOLD}) && !half_done) ? cnt + 1'b1 : '0;
      if (state == IDLE && load) sh <= load_data;
      if (state == SHIFT && half_done) begin
        chip_clk_out <= ~chip_clk_out;
        edges        <= last_edge ? '0 : edges + 1'b1;
        if (chip_clk_out) for (int k = 0; k < LINES; k++) sh[k] <= sh[k] << 1;
      end
      if (state == HOLD && half_done) packets_sent_out <= packets_sent_out + 1'b1;
    end
  end
endmodule

// File: rtl/multilane_spi_streamer.sv
// multilane_spi_streamer: decimate, pack LINES pixels per packet, 2-deep buffer, LINES-wide SPI out; MULTILANE_SPI_FRAME_SYNC_EN adds a sync packet at frame start
module multilane_spi_streamer
  import multilane_spi_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int LINES           = 6,
  parameter int DATA_CLK_PERIOD = 6,
  parameter int DS_SHIFT        = 1,
  parameter int HCOUNT_WIDTH    = 11,
  parameter int VCOUNT_WIDTH    = 10
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    pixel_valid_in,
  input  logic [DATA_WIDTH-1:0]   pixel_data_in,
  input  logic [HCOUNT_WIDTH-1:0] hcount_in,
  input  logic [VCOUNT_WIDTH-1:0] vcount_in,
  output logic [LINES-1:0]        chip_data_out,
  output logic                    chip_clk_out,
  output logic                    chip_sel_out,
  output logic                    busy_out,
  output logic                    overflow_out,
  output logic [15:0]             packets_sent_out
);
  localparam int LW = cnt_width(LINES);
  localparam logic [HCOUNT_WIDTH-1:0] H_MASK = HCOUNT_WIDTH'((1 << DS_SHIFT) - 1);
  localparam logic [VCOUNT_WIDTH-1:0] V_MASK = VCOUNT_WIDTH'((1 << DS_SHIFT) - 1);
  typedef logic [LINES-1:0][DATA_WIDTH-1:0] pkt_t;
  pkt_t pack, pack_nxt, commit_data, sync_pkt;
  pkt_t fifo_mem [2];
  logic [LW-1:0] lane_idx, slot;
  logic [1:0] count;
  logic accept, frame_start, fill, sync_commit, commit_q;
  logic wr_ptr, rd_ptr, push, pop, ready;
  assign frame_start = (hcount_in == '0) && (vcount_in == '0);
  assign accept      = pixel_valid_in && ((hcount_in & H_MASK) == '0) && ((vcount_in & V_MASK) == '0);
  assign slot        = frame_start ? '0 : lane_idx;
  assign fill        = accept && (slot == LW'(LINES - 1));
  assign sync_pkt    = {LINES{DATA_WIDTH'(SYNC_WORD)}};
`ifdef MULTILANE_SPI_FRAME_SYNC_EN
  assign sync_commit = accept && frame_start;
`else
  assign sync_commit = 1'b0;
`endif
  assign pop      = ready && (count != 2'd0);
  assign push     = commit_q && ((count != 2'd2) || pop);
  assign busy_out = !chip_sel_out || (count != 2'd0);
  // current packet with the incoming pixel dropped into its lane
  always_comb begin
    pack_nxt       = pack;
    pack_nxt[slot] = pixel_data_in;
  end
  // packer: frame start restarts at lane 0; a full packet (or sync word) commits next cycle
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pack        <= '0;
      lane_idx    <= '0;
      commit_q    <= 1'b0;
      commit_data <= '0;
    end else begin
      commit_q <= fill || sync_commit;
      if (accept) begin
        pack        <= pack_nxt;
        lane_idx    <= fill ? '0 : slot + 1'b1;
        commit_data <= sync_commit ? sync_pkt : pack_nxt;
      end
    end
  end
  // two-entry packet storage
  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= commit_data;
  end
  // buffer pointers and sticky overflow; a same-cycle pop frees the slot for a commit
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      overflow_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (commit_q && !push) overflow_out <= 1'b1;
    end
  end
  spi_lane_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .LINES(LINES),
    .DATA_CLK_PERIOD(DATA_CLK_PERIOD)
  ) u_ser (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .load(pop),
    .load_data(fifo_mem[rd_ptr]),
    .ready(ready),
    .chip_data_out(chip_data_out),
    .chip_clk_out(chip_clk_out),
    .chip_sel_out(chip_sel_out),
    .packets_sent_out(packets_sent_out)
  );
endmodule

// File: tb/tb_multilane_spi_streamer.sv
// tb_multilane_spi_streamer: directed scoreboard bench for multilane_spi_streamer
module tb_multilane_spi_streamer;
  import multilane_spi_pkg::*;
  typedef logic [5:0][15:0] pkt_t;
  logic clk_in = 1'b0, rst_in = 1'b0, pixel_valid_in = 1'b0;
  logic [15:0] pixel_data_in = '0;
  logic [10:0] hcount_in = '0;
  logic [9:0] vcount_in = '0;
  logic [5:0] chip_data_out;
  logic chip_clk_out, chip_sel_out, busy_out, overflow_out;
  logic [15:0] packets_sent_out;
  pkt_t exp_q[$];
  int n_assert = 0, n_fail = 0, exp_sent = 0;
  bit mon_en = 1'b1;
  always #5 clk_in = ~clk_in;
  multilane_spi_streamer dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .pixel_valid_in(pixel_valid_in),
    .pixel_data_in(pixel_data_in),
    .hcount_in(hcount_in),
    .vcount_in(vcount_in),
    .chip_data_out(chip_data_out),
    .chip_clk_out(chip_clk_out),
    .chip_sel_out(chip_sel_out),
    .busy_out(busy_out),
    .overflow_out(overflow_out),
    .packets_sent_out(packets_sent_out)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic px(input int h, input int v, input logic [15:0] d);
    @(negedge clk_in);
    pixel_valid_in = 1'b1;
    hcount_in      = 11'(h);
    vcount_in      = 10'(v);
    pixel_data_in  = d;
  endtask
  task automatic px_off;
    @(negedge clk_in);
    pixel_valid_in = 1'b0;
  endtask
  task automatic expect_pkt(input pkt_t p);
    exp_q.push_back(p);
    exp_sent++;
  endtask
  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk_in);
      ok = (exp_q.size() == 0) && chip_sel_out && !busy_out;
    end
    chk({tag, "_done"}, ok, 1'b1);
  endtask
`ifdef MULTILANE_SPI_FRAME_SYNC_EN
  function automatic pkt_t sync_pkt();
    pkt_t p;
    for (int k = 0; k < 6; k++) p[k] = SYNC_WORD;
    return p;
  endfunction
`endif
  // bus monitor: collects one word per lane on dclk rising edges while cs is low
  initial begin
    pkt_t got;
    int low_cnt, rises;
    logic prev_cs, prev_dclk;
    got = '0; low_cnt = 0; rises = 0; prev_cs = 1'b1; prev_dclk = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!chip_sel_out) begin
        if (prev_cs) begin got = '0; low_cnt = 0; rises = 0; end
        low_cnt++;
        if (chip_clk_out && !prev_dclk) begin
          rises++;
          for (int k = 0; k < 6; k++) got[k] = {got[k][14:0], chip_data_out[k]};
        end
      end else if (!prev_cs && mon_en) begin
        chk("cs_low_cycles", low_cnt, 102);
        chk("dclk_rises", rises, 16);
        chk("pkt_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("pkt_lanes", got, exp_q.pop_front());
      end
      prev_cs = chip_sel_out;
      prev_dclk = chip_clk_out;
    end
  end
  initial begin
    bit bad, found;
    int edges;
    logic prev;
    pkt_t e;
    repeat (3) @(negedge clk_in);
    chk("rst_cs", chip_sel_out, 1'b1);
    chk("rst_dclk", chip_clk_out, 1'b0);
    chk("rst_data", chip_data_out, 6'd0);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_ovf", overflow_out, 1'b0);
    chk("rst_sent", packets_sent_out, 16'd0);
    rst_in = 1'b1;
    // 12 consecutive pixels on row 0, only even columns kept
`ifdef MULTILANE_SPI_FRAME_SYNC_EN
    expect_pkt(sync_pkt());
`endif
    expect_pkt({16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111});
    for (int h = 0; h < 12; h++)
      px(h, 0, (h % 2 != 0) ? (16'hF0F0 ^ 16'(h)) : (16'h1111 * 16'(h / 2 + 1)));
    px_off;
`ifndef MULTILANE_SPI_FRAME_SYNC_EN
    chk("lat_cs_still_high", chip_sel_out, 1'b1);
    chk("busy_buffered", busy_out, 1'b1);
    @(negedge clk_in);
    chk("lat_cs_low", chip_sel_out, 1'b0);
`endif
    wait_idle("pkt1");
    chk("sent_pkt1", packets_sent_out, 16'(exp_sent));
    // odd rows are all decimated away
    bad = 1'b0;
    for (int h = 0; h < 20; h++) begin
      px(h, 1, 16'(h * 7 + 3));
      if (!chip_sel_out || busy_out) bad = 1'b1;
    end
    px_off;
    repeat (5) begin
      @(negedge clk_in);
      if (!chip_sel_out || busy_out) bad = 1'b1;
    end
    chk("odd_rows_idle", bad, 1'b0);
    chk("odd_rows_sent", packets_sent_out, 16'(exp_sent));
    // partial packet discarded by frame start
    px(0, 2, 16'hBAD0);
    px(2, 2, 16'hBAD1);
    px(4, 2, 16'hBAD2);
`ifdef MULTILANE_SPI_FRAME_SYNC_EN
    expect_pkt(sync_pkt());
`endif
    expect_pkt({16'h0F05, 16'h0F04, 16'h0F03, 16'h0F02, 16'h0F01, 16'h0F00});
    px(0, 0, 16'h0F00);
    for (int i = 1; i < 6; i++) px(2 * i, 0, 16'h0F00 + 16'(i));
    px_off;
    wait_idle("align");
    chk("align_sent", packets_sent_out, 16'(exp_sent));
    // four packets back to back: the fourth finds the buffer full
    chk("ovf_clear", overflow_out, 1'b0);
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 6; k++) e[k] = 16'((p + 1) * 'h1000 + k);
      expect_pkt(e);
    end
    for (int i = 0; i < 24; i++) px(2 * i, 4, 16'((i / 6 + 1) * 'h1000 + i % 6));
    px_off;
    @(negedge clk_in);
    chk("ovf_set", overflow_out, 1'b1);
    wait_idle("ovf");
    chk("ovf_sent", packets_sent_out, 16'(exp_sent));
    chk("ovf_sticky", overflow_out, 1'b1);
    // reset in the middle of a transfer
    for (int i = 0; i < 6; i++) px(2 * i, 6, 16'h7000 + 16'(i));
    px_off;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_in);
      found = !chip_sel_out;
    end
    chk("abort_pkt_started", found, 1'b1);
    repeat (30) @(negedge clk_in);
    mon_en = 1'b0;
    #1 rst_in = 1'b0;
    #1;
    chk("abort_cs", chip_sel_out, 1'b1);
    chk("abort_dclk", chip_clk_out, 1'b0);
    chk("abort_data", chip_data_out, 6'd0);
    chk("abort_sent", packets_sent_out, 16'd0);
    chk("abort_ovf", overflow_out, 1'b0);
    chk("abort_busy", busy_out, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b1;
    edges = 0;
    bad = 1'b0;
    prev = chip_clk_out;
    repeat (60) begin
      @(negedge clk_in);
      if (chip_clk_out !== prev) edges++;
      prev = chip_clk_out;
      if (!chip_sel_out) bad = 1'b1;
    end
    chk("abort_no_dclk", edges, 0);
    chk("abort_cs_high", bad, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
